// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchroniser, start/data/parity/stop deframing,
// one-entry valid/ready holding register and registered active-low RTS.
module uart_rx #(
   parameter int unsigned CLK_HZ          = 12_000_000,
   parameter int unsigned BAUD_RATE_BPS   = 9600,
   parameter int unsigned BAUD_RATE_COUNT = CLK_HZ / BAUD_RATE_BPS,
   parameter int unsigned UART_DATA_BITS  = 8,
   parameter int unsigned PARITY_BITS     = 0,
   parameter int unsigned STOP_BITS       = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      uart0_rxd,
   output logic                      uart0_rts,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic                      frame_err,
   output logic                      parity_err,
   output logic                      overrun
);

   localparam int unsigned HALF = BAUD_RATE_COUNT / 2;
   localparam int unsigned CW   = $clog2(BAUD_RATE_COUNT);
   localparam int unsigned IW   = $clog2(UART_DATA_BITS);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
   } state_e;

   state_e                    state_q, state_d;
   logic                      sync1_q, sync2_q;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      perr_q, perr_d;
   logic                      ferr_q, ferr_d;
   logic                      resolve_q, resolve_d;
   logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                      rx_valid_q, rx_valid_d;
   logic                      rts_q;
   logic                      frame_err_q, frame_err_d;
   logic                      parity_err_q, parity_err_d;
   logic                      overrun_q, overrun_d;
   logic                      rxs;
   logic                      handshake;

   assign rxs       = sync2_q;
   assign handshake = rx_valid_q && rx_ready;

   // Deframing FSM; data shifts in from the MSB so the first line bit ends at bit 0.
   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      resolve_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rxs) begin
               state_d = S_START;
               cnt_d   = CW'(HALF - 1);
            end
         end
         S_START: begin
            if (cnt_q == '0) begin
               if (rxs) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  cnt_d   = CW'(BAUD_RATE_COUNT - 1);
                  idx_d   = '0;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
               end
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
               cnt_d   = CW'(BAUD_RATE_COUNT - 1);
               if (idx_q == IW'(UART_DATA_BITS - 1)) begin
                  idx_d   = '0;
                  state_d = (PARITY_BITS != 0) ? S_PARITY : S_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (cnt_q == '0) begin
               perr_d  = rxs ^ (^shift_q);
               cnt_d   = CW'(BAUD_RATE_COUNT - 1);
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt_q == '0) begin
               ferr_d = ferr_q | ~rxs;
               if (idx_q == IW'(STOP_BITS - 1)) begin
                  resolve_d = 1'b1;
                  state_d   = ferr_d ? S_WAIT_HIGH : S_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
                  cnt_d = CW'(BAUD_RATE_COUNT - 1);
               end
            end
         end
         S_WAIT_HIGH: begin
            if (rxs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Frame resolution and holding register; a same-cycle handshake frees the slot.
   always_comb begin
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
      if (handshake) rx_valid_d = 1'b0;
      if (resolve_q) begin
         if (ferr_q) begin
            frame_err_d = 1'b1;
         end else if (perr_q) begin
            parity_err_d = 1'b1;
         end else if (!rx_valid_q || handshake) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         resolve_q    <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rts_q        <= 1'b1;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sync1_q      <= uart0_rxd;
         sync2_q      <= sync1_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
         resolve_q    <= resolve_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         rts_q        <= rx_valid_q;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign uart0_rts  = rts_q;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: 8N1 instance plus an even-parity instance,
// 10 clocks per bit; expected events queued by stimulus, popped by monitors.
module tb_uart_rx;

   localparam int COUNT = 10;
   localparam int K_DATA = 0, K_FERR = 1, K_PERR = 2, K_OVR = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       rxd, rxd_p;
   logic       rts, rts_p;
   logic [7:0] rx_data, rx_data_p;
   logic       rx_valid, rx_valid_p;
   logic       rx_ready, rx_ready_p;
   logic       frame_err, frame_err_p;
   logic       parity_err, parity_err_p;
   logic       overrun, overrun_p;

   int  tests = 0;
   int  fails = 0;
   ev_t q0[$];
   ev_t q1[$];

   always #5 clk = ~clk;

   uart_rx #(.CLK_HZ(1_000_000), .BAUD_RATE_BPS(100_000)) u_dut (
      .clk(clk), .reset(reset), .uart0_rxd(rxd), .uart0_rts(rts),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
   );

   uart_rx #(.CLK_HZ(1_000_000), .BAUD_RATE_BPS(100_000), .PARITY_BITS(1)) u_par (
      .clk(clk), .reset(reset), .uart0_rxd(rxd_p), .uart0_rts(rts_p),
      .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
      .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p)
   );

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input bit inst, input int kind, input logic [7:0] d);
      ev_t e;
      e.kind = kind;
      e.data = d;
      if (inst) q1.push_back(e);
      else      q0.push_back(e);
   endtask

   task automatic check_ev(input bit inst, input int kind, input logic [7:0] d);
      ev_t e;
      bit  empty;
      tests++;
      empty = inst ? (q1.size() == 0) : (q0.size() == 0);
      if (empty) begin
         fails++;
         $display("FAIL unexpected_event inst%0d: got kind=%0d data=%h expected none",
                  inst, kind, d);
      end else begin
         if (inst) e = q1.pop_front();
         else      e = q0.pop_front();
         if (e.kind != kind || e.data != d) begin
            fails++;
            $display("FAIL event inst%0d: got kind=%0d data=%h expected kind=%0d data=%h",
                     inst, kind, d, e.kind, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid && rx_ready) check_ev(1'b0, K_DATA, rx_data);
         if (frame_err)  check_ev(1'b0, K_FERR, 8'h00);
         if (parity_err) check_ev(1'b0, K_PERR, 8'h00);
         if (overrun)    check_ev(1'b0, K_OVR, 8'h00);
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid_p && rx_ready_p) check_ev(1'b1, K_DATA, rx_data_p);
         if (frame_err_p)  check_ev(1'b1, K_FERR, 8'h00);
         if (parity_err_p) check_ev(1'b1, K_PERR, 8'h00);
         if (overrun_p)    check_ev(1'b1, K_OVR, 8'h00);
      end
   end

   // Each bit occupies COUNT clock edges; returns on the last edge of the bit.
   task automatic drive_bit(input bit inst, input logic b);
      @(posedge clk);
      #1;
      if (inst) rxd_p = b;
      else      rxd   = b;
      repeat (COUNT - 1) @(posedge clk);
   endtask

   task automatic send_frame(input bit inst, input logic [7:0] d, input bit use_par,
                             input logic par, input logic stop);
      drive_bit(inst, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(inst, d[i]);
      if (use_par) drive_bit(inst, par);
      drive_bit(inst, stop);
   endtask

   task automatic drain(input bit inst);
      @(posedge clk);
      #1;
      if (inst) rx_ready_p = 1'b1;
      else      rx_ready   = 1'b1;
      @(posedge clk);
      #1;
      if (inst) rx_ready_p = 1'b0;
      else      rx_ready   = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      rxd        = 1'b1;
      rxd_p      = 1'b1;
      rx_ready   = 1'b0;
      rx_ready_p = 1'b0;

      // reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_rts", int'(rts), 1);
      chk("reset_valid", int'(rx_valid), 0);
      chk("reset_data", int'(rx_data), 0);
      chk("reset_flags", int'({frame_err, parity_err, overrun}), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("rts_after_reset", int'(rts), 0);

      // single byte 0xA5, exact latency
      push(1'b0, K_DATA, 8'hA5);
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("a5_valid", int'(rx_valid), 1);
      chk("a5_data", int'(rx_data), 8'hA5);
      chk("a5_rts_lag", int'(rts), 0);
      @(negedge clk);
      chk("a5_rts_full", int'(rts), 1);
      drain(1'b0);
      chk("a5_valid_clr", int'(rx_valid), 0);
      chk("a5_rts_still", int'(rts), 1);
      @(posedge clk);
      #1;
      chk("a5_rts_free", int'(rts), 0);

      // glitch rejection
      @(posedge clk);
      #1 rxd = 1'b0;
      repeat (3) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("glitch_no_valid", int'(rx_valid), 0);

      // framing error with stuck-low line, then recovery
      push(1'b0, K_FERR, 8'h00);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      repeat (30) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("ferr_no_valid", int'(rx_valid), 0);
      push(1'b0, K_DATA, 8'h5A);
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      drain(1'b0);

      // overrun: holding register full
      push(1'b0, K_OVR, 8'h00);
      push(1'b0, K_DATA, 8'h11);
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      drain(1'b0);
      chk("ovr_drained", int'(rx_valid), 0);

      // handshake on the resolution cycle frees the slot
      push(1'b0, K_DATA, 8'h11);
      push(1'b0, K_DATA, 8'h22);
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      fork
         send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
         begin
            @(posedge clk);
            repeat (98) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      @(negedge clk);
      chk("same_cycle_valid", int'(rx_valid), 1);
      chk("same_cycle_data", int'(rx_data), 8'h22);
      drain(1'b0);

      // even parity instance
      push(1'b1, K_PERR, 8'h00);
      send_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("perr_no_valid", int'(rx_valid_p), 0);
      push(1'b1, K_DATA, 8'h01);
      send_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      drain(1'b1);

      repeat (5) @(posedge clk);
      #1;
      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
